// File: rtl/seg7_scanner.sv
// seg7_scanner: time-multiplexes a 2x2 result frame (four patterns plus
// four sign flags) onto a single 7-segment display as sign, digit and gap
// phases. New frames loaded mid-scan wait in a pending buffer and are
// swapped in only at the frame boundary, so a frame is never shown torn.
module seg7_scanner #(
    parameter int DWELL = 16,
    parameter int GAP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    input  logic [6:0] seg3,
    input  logic [6:0] seg4,
    input  logic       neg1,
    input  logic       neg2,
    input  logic       neg3,
    input  logic       neg4,
    output logic [6:0] segments,
    output logic       dp,
    output logic [1:0] digit_idx,
    output logic       busy,
    output logic       pending,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SIGN,
        ST_DIGIT,
        ST_GAP
    } stateT;

    localparam logic [15:0] DWELL_LOAD = 16'(DWELL - 1);
    localparam logic [15:0] GAP_LOAD   = 16'(GAP - 1);
    localparam logic [6:0]  MINUS      = 7'b1000000;

    stateT       state, stateNext;
    logic [1:0]  idx, idxNext;
    logic [15:0] cnt, cntNext;
    // Each element occupies one byte: bit 7 = sign, bits 6:0 = pattern.
    logic [31:0] activeBuf, activeNext;
    logic [31:0] pendingBuf, pendingBufNext;
    logic        pendingNext;
    logic [31:0] loadWord;
    logic        phaseEnd;
    logic        frameEnd;
    logic [6:0]  segNext;
    logic        dpNext;
    logic        frameDoneNext;

    assign loadWord = {neg4, seg4, neg3, seg3, neg2, seg2, neg1, seg1};
    assign phaseEnd = (cnt == 16'd0);
    assign frameEnd = (state == ST_GAP) && (idx == 2'd3) && phaseEnd;

    // Next-state, buffer management and the registered-output look-ahead.
    always_comb begin
        stateNext      = state;
        idxNext        = idx;
        cntNext        = (cnt == 16'd0) ? cnt : cnt - 16'd1;
        activeNext     = activeBuf;
        pendingBufNext = pendingBuf;
        pendingNext    = pending;

        case (state)
            ST_IDLE: begin
                if (load) begin
                    activeNext = loadWord;
                    idxNext    = 2'd0;
                    cntNext    = DWELL_LOAD;
                    stateNext  = loadWord[7] ? ST_SIGN : ST_DIGIT;
                end
            end
            ST_SIGN: begin
                if (phaseEnd) begin
                    stateNext = ST_DIGIT;
                    cntNext   = DWELL_LOAD;
                end
            end
            ST_DIGIT: begin
                if (phaseEnd) begin
                    stateNext = ST_GAP;
                    cntNext   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (phaseEnd) begin
                    if (idx != 2'd3) begin
                        idxNext   = idx + 2'd1;
                        stateNext = activeBuf[{idxNext, 3'b111}] ? ST_SIGN : ST_DIGIT;
                    end else begin
                        // A load landing exactly on the boundary wins over
                        // whatever was pending and goes straight to active.
                        if (load) begin
                            activeNext  = loadWord;
                            pendingNext = 1'b0;
                        end else if (pending) begin
                            activeNext  = pendingBuf;
                            pendingNext = 1'b0;
                        end
                        idxNext   = 2'd0;
                        stateNext = activeNext[7] ? ST_SIGN : ST_DIGIT;
                    end
                    cntNext = (stateNext == ST_GAP) ? GAP_LOAD : DWELL_LOAD;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase

        if (load && (state != ST_IDLE) && !frameEnd) begin
            pendingBufNext = loadWord;
            pendingNext    = 1'b1;
        end

        segNext = 7'd0;
        case (stateNext)
            ST_SIGN:  segNext = MINUS;
            ST_DIGIT: segNext = activeNext[{idxNext, 3'b000} +: 7];
            default:  segNext = 7'd0;
        endcase
        dpNext        = (stateNext == ST_DIGIT) && (idxNext == 2'd3);
        frameDoneNext = (stateNext == ST_GAP) && (idxNext == 2'd3) && (cntNext == 16'd0);
    end

    // State, buffers and all outputs update together on the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            cnt        <= 16'd0;
            activeBuf  <= 32'd0;
            pendingBuf <= 32'd0;
            pending    <= 1'b0;
            segments   <= 7'd0;
            dp         <= 1'b0;
            digit_idx  <= 2'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= stateNext;
            idx        <= idxNext;
            cnt        <= cntNext;
            activeBuf  <= activeNext;
            pendingBuf <= pendingBufNext;
            pending    <= pendingNext;
            segments   <= segNext;
            dp         <= dpNext;
            digit_idx  <= idxNext;
            busy       <= (stateNext != ST_IDLE);
            frame_done <= frameDoneNext;
        end
    end

endmodule

// File: tb/tb_seg7_scanner.sv
// Scoreboard bench for seg7_scanner: stimulus pushes the expected per-cycle
// display timeline into a queue, a monitor pops and compares each cycle.
module tb_seg7_scanner;

    localparam int DW = 4;
    localparam int GP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [27:0] segIn = '0;
    logic [3:0]  negIn = '0;
    logic [6:0] segments;
    logic       dp;
    logic [1:0] digit_idx;
    logic       busy;
    logic       pending;
    logic       frame_done;

    seg7_scanner #(.DWELL(DW), .GAP(GP)) dut (
        .clk(clk), .rst(rst), .load(load),
        .seg1(segIn[6:0]), .seg2(segIn[13:7]), .seg3(segIn[20:14]), .seg4(segIn[27:21]),
        .neg1(negIn[0]), .neg2(negIn[1]), .neg3(negIn[2]), .neg4(negIn[3]),
        .segments(segments), .dp(dp), .digit_idx(digit_idx), .busy(busy),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Packed snapshot: {seg[6:0], dp, idx[1:0], busy, pending, frame_done}
    typedef struct {
        int          cyc;
        logic [12:0] v;
    } expT;
    expT q[$];

    int checks = 0;
    int errors = 0;

    function automatic logic [12:0] snap();
        return {segments, dp, digit_idx, busy, pending, frame_done};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got {seg,dp,idx,busy,pend,fd}=%h required %h", name, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the scoreboard head every cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_entry cyc=%0d required %h", q[0].cyc, q[0].v);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            expT e;
            e = q.pop_front();
            check($sformatf("scan_cyc%0d", cyc), snap(), e.v);
        end
    end

    task automatic push(input int c, input logic [12:0] v);
        expT e;
        e.cyc = c;
        e.v   = v;
        q.push_back(e);
    endtask

    // Expected timeline of one frame starting at cycle base.
    task automatic pushFrame(input int base, input logic [27:0] pats, input logic [3:0] negs,
                             output int nextCyc);
        int c;
        c = base;
        for (int e = 0; e < 4; e++) begin
            if (negs[e])
                for (int k = 0; k < DW; k++) push(c++, {7'h40, 1'b0, 2'(e), 3'b100});
            for (int k = 0; k < DW; k++) push(c++, {pats[e*7 +: 7], (e == 3), 2'(e), 3'b100});
            for (int k = 0; k < GP; k++)
                push(c++, {7'h00, 1'b0, 2'(e), 2'b10, (e == 3 && k == GP - 1)});
        end
        nextCyc = c;
    endtask

    task automatic setPend(input int from, input int to);
        for (int i = 0; i < q.size(); i++)
            if (q[i].cyc >= from && q[i].cyc <= to) q[i].v[1] = 1'b1;
    endtask

    // Called at a negedge; the load is sampled at the next rising edge.
    task automatic doLoad(input logic [27:0] pats, input logic [3:0] negs);
        segIn = pats;
        negIn = negs;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        segIn = '0;
        negIn = '0;
    endtask

    task automatic loadAtEdge(input int edgeNum, input logic [27:0] pats, input logic [3:0] negs);
        for (int i = 0; i < 1000 && cyc < edgeNum - 1; i++) @(negedge clk);
        doLoad(pats, negs);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d entries left required 0", q.size());
            q.delete();
        end
    endtask

    task automatic doReset(input string name);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check(name, snap(), 13'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [27:0] FA = {7'h66, 7'h4F, 7'h5B, 7'h06};
    localparam logic [27:0] FB = {7'h7F, 7'h07, 7'h7D, 7'h6D};
    localparam logic [27:0] FC = {7'h3F, 7'h71, 7'h39, 7'h77};
    localparam logic [27:0] FD = {7'h5E, 7'h7C, 7'h79, 7'h01};

    initial begin
        int p;
        int n;

        // Reset then idle
        #3 rst = 1'b1;
        #1 check("reset_async", snap(), 13'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 100; i++) push(cyc + i, 13'h0);
        drain();

        // Single all-positive frame, repeated
        @(negedge clk);
        p = cyc + 1;
        pushFrame(p, FA, 4'b0000, n);
        pushFrame(n, FA, 4'b0000, n);
        doLoad(FA, 4'b0000);
        drain();
        doReset("reset_after_a");

        // Negative elements 1 and 3 (frame length 32)
        @(negedge clk);
        p = cyc + 1;
        pushFrame(p, FA, 4'b0101, n);
        if (n - p != 32) $display("note: frame length %0d", n - p);
        pushFrame(n, FA, 4'b0101, n);
        doLoad(FA, 4'b0101);
        drain();
        doReset("reset_after_neg");

        // Mid-frame reload: B then C, C wins at the boundary
        @(negedge clk);
        p = cyc + 1;
        pushFrame(p, FA, 4'b0000, n);
        setPend(p + 10, p + 23);
        pushFrame(n, FC, 4'b0010, n);
        doLoad(FA, 4'b0000);
        loadAtEdge(p + 10, FB, 4'b1111);
        loadAtEdge(p + 12, FC, 4'b0010);
        drain();
        doReset("reset_after_reload");

        // Boundary collision: load on the frame_done cycle
        @(negedge clk);
        p = cyc + 1;
        pushFrame(p, FA, 4'b0000, n);
        pushFrame(n, FD, 4'b1001, n);
        doLoad(FA, 4'b0000);
        loadAtEdge(p + 24, FD, 4'b1001);
        drain();
        doReset("reset_after_collision");

        // Reset during a DIGIT phase with a frame pending
        @(negedge clk);
        p = cyc + 1;
        pushFrame(p, FA, 4'b0000, n);
        while (q.size() > 0 && q[q.size() - 1].cyc > p + 11) void'(q.pop_back());
        setPend(p + 10, p + 11);
        doLoad(FA, 4'b0000);
        loadAtEdge(p + 10, FB, 4'b0000);
        for (int i = 0; i < 100 && cyc < p + 12; i++) @(negedge clk);
        check("pre_reset_digit", snap(), {7'h4F, 1'b0, 2'd2, 3'b110});
        #1 rst = 1'b1;
        #1 check("reset_mid_frame", snap(), 13'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        p = cyc + 1;
        pushFrame(p, FC, 4'b0010, n);
        doLoad(FC, 4'b0010);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
